// File: rtl/timer_dev_pkg.sv
// Shared definitions for the memory-mapped down-counting timer:
// register offsets, CTRL bit positions, mode encodings and FSM states.
package timer_dev_pkg;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_PRESET = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;

    localparam int EN       = 0;
    localparam int MODE_LSB = 1;
    localparam int MODE_MSB = 2;
    localparam int IM       = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } tmr_state_e;

endpackage

// File: rtl/timer_dev.sv
// 32-bit down-counting timer behind the system bridge: CTRL/PRESET/COUNT
// registers, a four-state count FSM and a maskable interrupt line.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter int CTRL_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq,
    output logic [1:0]  dbg_state_o
);

    logic [CTRL_W-1:0] ctrl_q,     ctrl_d;
    logic [31:0]       preset_q,   preset_d;
    logic [31:0]       count_q,    count_d;
    logic              irq_flag_q, irq_flag_d;
    tmr_state_e        state_q,    state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            state_q    <= IDLE;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            state_q    <= state_d;
        end
    end

    // FSM first, then bus writes, so a CPU CTRL write overrides the
    // one-shot Enable clear issued from INT on the same edge.
    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
        state_d    = state_q;

        case (state_q)
            IDLE: begin
                if (ctrl_q[EN]) state_d = LOAD;
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!ctrl_q[EN]) begin
                    state_d = IDLE;
                end else if (count_q <= 32'd1) begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            INT: begin
                if (ctrl_q[MODE_MSB:MODE_LSB] == MODE_RELOAD) begin
                    irq_flag_d = 1'b0;
                    state_d    = LOAD;
                end else begin
                    ctrl_d[EN] = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (we) begin
            case (addr)
                TMR_CTRL: begin
                    ctrl_d     = wd[CTRL_W-1:0];
                    irq_flag_d = 1'b0;
                end
                TMR_PRESET: preset_d = wd;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd = '0;
        case (addr)
            TMR_CTRL:   rd = {{(32-CTRL_W){1'b0}}, ctrl_q};
            TMR_PRESET: rd = preset_q;
            TMR_COUNT:  rd = count_q;
            default:    rd = '0;
        endcase
    end

    assign irq         = irq_flag_q & ctrl_q[IM];
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: register access, one-shot, auto-reload,
// masking, pause/restart and the count boundary cases.
module tb_timer_dev;
    import timer_dev_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    timer_dev #(.CTRL_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .we          (we),
        .wd          (wd),
        .rd          (rd),
        .irq         (irq),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish in 200000 time units");
        $fatal(1);
    end

    task automatic do_reset();
        we    = 1'b0;
        addr  = 2'd0;
        wd    = '0;
        rst_n = 1'b0;
        #7;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    // Returns 1 time unit after the edge that performed the write.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic rd_at(input logic [1:0] a, output logic [31:0] v);
        addr = a;
        #1;
        v = rd;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            rd_at(2'(a), v);
            n_tests++;
            if (v !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_rd addr=%0d got=%h exp=0", a, v);
            end
        end
        n_tests++;
        if (irq !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state irq=%b state=%0d exp irq=0 state=0", irq, dbg_state);
        end
        wr(TMR_PRESET, 32'd5);
        wr(TMR_CTRL, 32'h9);
        tick(2);
        rd_at(TMR_COUNT, v);
        n_tests++;
        if (v !== 32'd5) begin
            n_fail++;
            $display("FAIL reset_precount got=%0d exp=5", v);
        end
        #1;
        rst_n = 1'b0;
        for (int a = 0; a < 3; a++) begin
            rd_at(2'(a), v);
            n_tests++;
            if (v !== 32'd0) begin
                n_fail++;
                $display("FAIL async_reset_rd addr=%0d got=%h exp=0", a, v);
            end
        end
        n_tests++;
        if (irq !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL async_reset_state irq=%b state=%0d exp 0/0", irq, dbg_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_one_shot();
        logic [31:0] v;
        do_reset();
        wr(TMR_PRESET, 32'd3);
        wr(TMR_CTRL, 32'h9);
        tick(2);
        for (int i = 0; i < 4; i++) begin
            rd_at(TMR_COUNT, v);
            n_tests++;
            if (v !== 32'(3 - i) || irq !== (i == 3)) begin
                n_fail++;
                $display("FAIL oneshot_count step=%0d count=%0d irq=%b exp count=%0d irq=%b",
                         i, v, irq, 3 - i, (i == 3));
            end
            if (i < 3) tick(1);
        end
        tick(1);
        rd_at(TMR_CTRL, v);
        n_tests++;
        if (v !== 32'h8 || irq !== 1'b1 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL oneshot_done ctrl=%h irq=%b state=%0d exp ctrl=8 irq=1 state=0",
                     v, irq, dbg_state);
        end
        tick(2);
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL oneshot_hold irq=%b exp=1", irq);
        end
        wr(TMR_CTRL, 32'h8);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL oneshot_clear irq=%b exp=0", irq);
        end
    endtask

    task automatic test_auto_reload();
        logic [31:0] v;
        logic [31:0] exp_c;
        logic        exp_i;
        do_reset();
        wr(TMR_PRESET, 32'd2);
        wr(TMR_CTRL, 32'hB);
        tick(2);
        // Period of 4 edges: 2,1,0 (irq),0 (LOAD), then reload to 2.
        for (int i = 0; i < 12; i++) begin
            exp_c = (i % 4 == 3) ? 32'd0 : 32'(2 - (i % 4));
            exp_i = (i % 4 == 2);
            rd_at(TMR_COUNT, v);
            n_tests++;
            if (v !== exp_c || irq !== exp_i) begin
                n_fail++;
                $display("FAIL reload_seq step=%0d count=%0d irq=%b exp count=%0d irq=%b",
                         i, v, irq, exp_c, exp_i);
            end
            tick(1);
        end
    endtask

    task automatic test_mask();
        logic [31:0] v;
        do_reset();
        wr(TMR_PRESET, 32'd1);
        wr(TMR_CTRL, 32'h1);
        tick(3);
        rd_at(TMR_COUNT, v);
        n_tests++;
        if (v !== 32'd0 || irq !== 1'b0 || dbg_state !== INT) begin
            n_fail++;
            $display("FAIL mask_int count=%0d irq=%b state=%0d exp count=0 irq=0 state=3",
                     v, irq, dbg_state);
        end
        tick(1);
        rd_at(TMR_CTRL, v);
        n_tests++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_after ctrl=%h irq=%b exp ctrl=0 irq=0", v, irq);
        end
        wr(TMR_CTRL, 32'h8);
        tick(1);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_set_im irq=%b exp=0", irq);
        end
    endtask

    task automatic test_pause_restart();
        logic [31:0] v;
        do_reset();
        wr(TMR_PRESET, 32'd10);
        wr(TMR_CTRL, 32'h9);
        tick(5);
        rd_at(TMR_COUNT, v);
        n_tests++;
        if (v !== 32'd7) begin
            n_fail++;
            $display("FAIL pause_pre count=%0d exp=7", v);
        end
        // This edge still decrements 7->6; the FSM sees Enable=0 next edge.
        wr(TMR_CTRL, 32'h8);
        tick(1);
        n_tests++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL pause_state state=%0d exp=0", dbg_state);
        end
        for (int i = 0; i < 5; i++) begin
            rd_at(TMR_COUNT, v);
            n_tests++;
            if (v !== 32'd6) begin
                n_fail++;
                $display("FAIL pause_frozen cycle=%0d count=%0d exp=6", i, v);
            end
            tick(1);
        end
        wr(TMR_CTRL, 32'h9);
        tick(2);
        rd_at(TMR_COUNT, v);
        n_tests++;
        if (v !== 32'd10) begin
            n_fail++;
            $display("FAIL restart_reload count=%0d exp=10", v);
        end
    endtask

    task automatic test_edge_cases();
        logic [31:0] v;
        do_reset();
        wr(TMR_COUNT, 32'h1234);
        rd_at(TMR_COUNT, v);
        n_tests++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL count_ro got=%h exp=0", v);
        end
        wr(2'd3, 32'hFFFF_FFFF);
        rd_at(2'd3, v);
        n_tests++;
        if (v !== 32'd0) begin
            n_fail++;
            $display("FAIL reserved_rd got=%h exp=0", v);
        end
        wr(TMR_CTRL, 32'hFFFF_FFF6);
        rd_at(TMR_CTRL, v);
        n_tests++;
        if (v !== 32'h6) begin
            n_fail++;
            $display("FAIL ctrl_width got=%h exp=6", v);
        end
        // PRESET=0 with mode 10 (one-shot behaviour): INT one edge after LOAD.
        wr(TMR_PRESET, 32'd0);
        wr(TMR_CTRL, 32'hD);
        tick(2);
        n_tests++;
        if (dbg_state !== CNT || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL preset0_cnt state=%0d irq=%b exp state=2 irq=0", dbg_state, irq);
        end
        tick(1);
        n_tests++;
        if (dbg_state !== INT || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL preset0_int state=%0d irq=%b exp state=3 irq=1", dbg_state, irq);
        end
        tick(1);
        rd_at(TMR_CTRL, v);
        n_tests++;
        if (v !== 32'hC || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL mode1x_oneshot ctrl=%h state=%0d exp ctrl=c state=0", v, dbg_state);
        end
    endtask

    task automatic test_preset_during_count();
        logic [31:0] v;
        do_reset();
        wr(TMR_PRESET, 32'd3);
        wr(TMR_CTRL, 32'hB);
        tick(3);
        wr(TMR_PRESET, 32'd7);
        rd_at(TMR_COUNT, v);
        n_tests++;
        if (v !== 32'd1) begin
            n_fail++;
            $display("FAIL preset_mid_count count=%0d exp=1", v);
        end
        tick(1);
        rd_at(TMR_COUNT, v);
        n_tests++;
        if (v !== 32'd0 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL preset_mid_int count=%0d irq=%b exp count=0 irq=1", v, irq);
        end
        tick(2);
        rd_at(TMR_COUNT, v);
        n_tests++;
        if (v !== 32'd7) begin
            n_fail++;
            $display("FAIL preset_mid_reload count=%0d exp=7", v);
        end
    endtask

    task automatic test_write_during_int();
        logic [31:0] v;
        do_reset();
        wr(TMR_PRESET, 32'd1);
        wr(TMR_CTRL, 32'h9);
        tick(3);
        n_tests++;
        if (dbg_state !== INT || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL wint_reach state=%0d irq=%b exp state=3 irq=1", dbg_state, irq);
        end
        wr(TMR_CTRL, 32'h9);
        rd_at(TMR_CTRL, v);
        n_tests++;
        if (v !== 32'h9 || irq !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL wint_cpu_wins ctrl=%h irq=%b state=%0d exp ctrl=9 irq=0 state=0",
                     v, irq, dbg_state);
        end
        tick(2);
        rd_at(TMR_COUNT, v);
        n_tests++;
        if (v !== 32'd1 || dbg_state !== CNT) begin
            n_fail++;
            $display("FAIL wint_rerun count=%0d state=%0d exp count=1 state=2", v, dbg_state);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst_n = 1'b0;
        we    = 1'b0;
        addr  = 2'd0;
        wd    = '0;
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_mask();
        test_pause_restart();
        test_edge_cases();
        test_preset_during_count();
        test_write_during_int();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
Memory-mapped 32-bit down-counting timer. It sits directly downstream of the system bridge as Dev1 (window 0x0000_7F00–0x0000_7F0F) or Dev2 (window 0x0000_7F10–0x0000_7F1F). It consumes the bridge's DevAddr[3:2], DevWd and per-device write enable, returns read data, and raises the per-device interrupt line that the bridge forwards into HWInt.

Parameters:
- CTRL_W, 4, implemented width of the CTRL register. Upper bits of CTRL read as 0 and ignore writes.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- addr  input  2  register select; connects to bridge DevAddr[3:2].
- we  input  1  write strobe; connects to bridge DevN_WE.
- wd  input  32  write data; connects to bridge DevWd.
- rd  output  32  read data, combinational from addr; connects to DevN_RD.
- irq  output  1  interrupt request, registered; connects to DevN_Irq.

Behaviour:
- Register map (word offsets):
  - 0 = CTRL[3:0]. Bit 0 is Enable. Bits 2:1 are Mode (00 one-shot, 01 auto-reload, 1x treated as 00). Bit 3 is IM (interrupt mask; 1 = irq allowed).
  - 1 = PRESET[31:0], read/write.
  - 2 = COUNT[31:0], read-only; writes are ignored.
  - 3 = reserved; reads 0, writes are ignored.
- Reset (rst_n=0, asynchronous): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, so irq=0. A reset mid-count aborts the count immediately.
- Writes:
  - Take effect on the rising edge while we=1.
  - CTRL takes wd[3:0].
  - PRESET takes wd.
  - Any CTRL write clears irq_flag.
- Reads: combinational, zero latency.
  - addr 0 returns {28'b0, CTRL}.
  - addr 1 returns PRESET.
  - addr 2 returns COUNT.
  - addr 3 returns 0.
- irq = irq_flag & CTRL[3].
- FSM, evaluated each rising edge:
  - IDLE: if Enable=1, go to LOAD; otherwise stay. COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If Enable=0, go to IDLE; COUNT holds its value.
    - Else if COUNT<=1, COUNT <= 0, irq_flag <= 1, go to INT.
    - Else COUNT <= COUNT-1.
  - INT, one-shot mode (00/1x): CTRL[0] <= 0; go to IDLE. irq_flag stays 1 until the next CTRL write.
  - INT, auto-reload mode (01): go to LOAD. irq_flag is cleared on the edge leaving INT, giving a one-cycle pulse.
- Latency: Enable written at edge N. COUNT=PRESET after edge N+2. irq rises after edge N+max(PRESET,1)+2.
- Boundary conditions:
  - PRESET=0 or 1: INT is reached one edge after LOAD.
  - No wrap-around: COUNT never decrements below 0.
  - PRESET write during CNT: the running count is unaffected; the new value is used at the next LOAD.
  - CPU CTRL write on the same edge as INT's Enable clear: the CPU write wins. The CTRL value comes from wd, and irq_flag is cleared.
  - CTRL write with Enable=0 during CNT: state is IDLE one edge later; COUNT is frozen and readable.
  - Re-enable from IDLE always reloads PRESET; there is no resume.
  - IM=0: irq_flag still sets and the state machine runs; irq stays 0. Setting IM later while irq_flag=1 asserts irq immediately, unless the same write clears the flag (a CTRL write always clears it).

Decomposition:
- Shared package holds:
  - register offsets: TMR_CTRL=2'd0, TMR_PRESET=2'd1, TMR_COUNT=2'd2
  - CTRL bit indices: EN=0, MODE=2:1, IM=3
  - mode encodings: MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01
  - state encoding: IDLE, LOAD, CNT, INT (2-bit)
- No sub-module. The register file and FSM are one module, and two instances serve Dev1 and Dev2.

Test Plan:
- Reset: assert rst_n=0 mid-count (COUNT=5) → rd=0 at addrs 0/1/2 and irq=0 immediately, without waiting for a clock.
- One-shot: write PRESET=3, then CTRL=0x9 (IM=1, one-shot, EN=1) at edge N → COUNT reads 3,2,1,0 after edges N+2..N+5. irq=1 after N+5, CTRL reads 0x8. irq holds until a CTRL write of 0x8, after which irq=0 one edge later.
- Auto-reload: PRESET=2, CTRL=0xB → irq is a 1-cycle pulse every 4 cycles, and COUNT sequence 2,1,0,(LOAD)2,... repeats for at least 3 periods.
- Mask: PRESET=1, CTRL=0x1 → irq stays 0 while COUNT reaches 0. A subsequent CTRL write of 0x8 → irq stays 0 because the flag is cleared.
- Pause/restart: PRESET=10, CTRL=0x9, then CTRL=0x8 when COUNT=6 → COUNT frozen at 6 for 5 cycles. CTRL=0x9 again → COUNT restarts from 10.
- Edge cases:
  - PRESET=0 → INT reached one edge after LOAD.
  - Write to addr 2 (0x1234) → ignored.
  - Read addr 3 → 0.
  - PRESET write of 7 during CNT → the current count completes; the next reload in mode 01 loads 7.
